// File: rtl/df_tap_scheduler_pkg.sv
// Shared definitions for the tap scheduler: default sizing and FSM state encoding.
package df_tap_scheduler_pkg;

    localparam int NTAPS_DEFAULT = 4;
    localparam int DW_DEFAULT    = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/df_tap_line.sv
// Sample delay line: shifts a new sample in on enable, clears on flush,
// and offers one tap through an indexed combinational read port.
module df_tap_line
    import df_tap_scheduler_pkg::*;
#(
    parameter int NTAPS = NTAPS_DEFAULT,
    parameter int DW    = DW_DEFAULT,
    localparam int IW   = $clog2(NTAPS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          shift_en,
    input  logic [DW-1:0] din,
    input  logic [IW-1:0] rd_idx,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] tap_q [NTAPS];
    logic [DW-1:0] tap_d [NTAPS];

    // Next-state of the delay line: flush wins over a shift.
    always_comb begin
        for (int k = 0; k < NTAPS; k++) begin
            tap_d[k] = tap_q[k];
        end
        if (flush) begin
            for (int k = 0; k < NTAPS; k++) begin
                tap_d[k] = '0;
            end
        end else if (shift_en) begin
            tap_d[0] = din;
            for (int k = 1; k < NTAPS; k++) begin
                tap_d[k] = tap_q[k-1];
            end
        end
    end

    // Tap storage with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NTAPS; k++) begin
                tap_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NTAPS; k++) begin
                tap_q[k] <= tap_d[k];
            end
        end
    end

    assign rd_data = tap_q[rd_idx];

endmodule

// File: rtl/df_tap_scheduler.sv
// FIR tap scheduler: time-multiplexes one external coefficient multiplier
// over NTAPS taps, one tap per cycle, and accumulates the products.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends on ready. in_ready is combinational from
// out_ready only in DONE, so a result can be released and the next sample
// taken on the same edge.
module df_tap_scheduler
    import df_tap_scheduler_pkg::*;
#(
    parameter int NTAPS = NTAPS_DEFAULT,
    parameter int DW    = DW_DEFAULT,
    parameter int ACCW  = DW + $clog2(NTAPS),
    localparam int IW   = $clog2(NTAPS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    output logic [DW-1:0]   mul_data,
    output logic [IW-1:0]   mul_sel,
    input  logic [DW-1:0]   mul_prod,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ACCW-1:0] out_data,
    output logic            busy,
    output logic [1:0]      dbg_state
);

    state_e          state_q, state_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            tap_shift;
    logic [DW-1:0]   tap_rd;
    logic            in_hs;
    logic            out_hs;

    df_tap_line #(
        .NTAPS (NTAPS),
        .DW    (DW)
    ) u_tap_line (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .shift_en (tap_shift),
        .din      (in_data),
        .rd_idx   (idx_q),
        .rd_data  (tap_rd)
    );

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign in_hs     = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign out_hs    = out_valid && out_ready;
    assign busy      = (state_q == ST_MAC);
    assign out_data  = acc_q;
    assign mul_sel   = busy ? idx_q  : '0;
    assign mul_data  = busy ? tap_rd : '0;
    assign dbg_state = state_q;

    // Scheduler next-state: accept, step through taps, then hold the result.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        tap_shift = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_hs) begin
                        tap_shift = 1'b1;
                        acc_d     = '0;
                        idx_d     = '0;
                        state_d   = ST_MAC;
                    end
                end
                ST_MAC: begin
                    acc_d = acc_q + ACCW'(mul_prod);
                    idx_d = idx_q + IW'(1);
                    if (idx_q == IW'(NTAPS - 1)) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    // in_hs in DONE implies out_hs, giving back-to-back flow.
                    if (in_hs) begin
                        tap_shift = 1'b1;
                        acc_d     = '0;
                        idx_d     = '0;
                        state_d   = ST_MAC;
                    end else if (out_hs) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, accumulator and tap index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
        end
    end

endmodule
